// File: rtl/cordic_engine_if.sv
// cordic_engine_if: request/result bundle between a CORDIC client and the engine.
// Latency: none, signals only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface cordic_engine_if #(
   parameter int WIDTH       = 16,
   parameter int ANGLE_WIDTH = 32
);
   logic                          in_valid;
   logic                          in_ready;
   logic                          mode;
   logic signed [WIDTH-1:0]       x_in;
   logic signed [WIDTH-1:0]       y_in;
   logic signed [ANGLE_WIDTH-1:0] z_in;
   logic                          out_valid;
   logic                          out_ready;
   logic signed [WIDTH-1:0]       x_out;
   logic signed [WIDTH-1:0]       y_out;
   logic signed [ANGLE_WIDTH-1:0] z_out;
   logic                          sat;

   modport master (
      output in_valid, mode, x_in, y_in, z_in, out_ready,
      input  in_ready, out_valid, x_out, y_out, z_out, sat
   );

   modport slave (
      input  in_valid, mode, x_in, y_in, z_in, out_ready,
      output in_ready, out_valid, x_out, y_out, z_out, sat
   );
endinterface

// File: rtl/cordic_engine.sv
// cordic_engine: iterative CORDIC (rotation or vectoring) with full-circle pre-reduction and saturating outputs.
// Latency: result valid after ITERATIONS edges from acceptance; one result per ITERATIONS+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, requests are never queued.
module cordic_engine #(
   parameter int WIDTH       = 16,
   parameter int ITERATIONS  = 15,
   parameter int ANGLE_WIDTH = 32
) (
   input  logic           clock,
   input  logic           reset,
   cordic_engine_if.slave bus
);
   // Two guard bits absorb the CORDIC gain and the negation of the most negative input.
   localparam int DW    = WIDTH + 2;
   localparam int CNT_W = $clog2(ITERATIONS + 1);

   typedef logic signed [DW-1:0]          data_t;
   typedef logic signed [ANGLE_WIDTH-1:0] angle_t;
   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   // Angle constants are held with 29 fraction bits and rescaled (rounded) to ANGLE_WIDTH.
   localparam int          ASH = (ANGLE_WIDTH >= 32) ? (ANGLE_WIDTH - 32) : (32 - ANGLE_WIDTH);
   localparam logic [63:0] RND = (ANGLE_WIDTH < 32) ? (64'd1 << ((ASH > 0) ? ASH - 1 : 0)) : 64'd0;

   function automatic angle_t to_angle(input logic [63:0] v);
      return (ANGLE_WIDTH >= 32) ? angle_t'(v << ASH) : angle_t'((v + RND) >> ASH);
   endfunction

   // round(atan(2^-i) * 2^29); beyond i = 12 the table is exactly 2^(29-i).
   function automatic logic [63:0] atan_base(input int i);
      logic [63:0] v;
      case (i)
         0:       v = 64'd421657428;
         1:       v = 64'd248918915;
         2:       v = 64'd131521918;
         3:       v = 64'd66762579;
         4:       v = 64'd33510843;
         5:       v = 64'd16771758;
         6:       v = 64'd8387925;
         7:       v = 64'd4194219;
         8:       v = 64'd2097141;
         9:       v = 64'd1048575;
         10:      v = 64'd524288;
         11:      v = 64'd262144;
         12:      v = 64'd131072;
         default: v = (i >= 0 && i <= 29) ? (64'd1 << (29 - i)) : 64'd0;
      endcase
      return v;
   endfunction

   localparam angle_t PI      = to_angle(64'd1686629713);
   localparam angle_t HALF_PI = PI >>> 1;

   function automatic logic in_range(input data_t v);
      return (&v[DW-1:WIDTH-1]) | ~(|v[DW-1:WIDTH-1]);
   endfunction

   function automatic logic [WIDTH-1:0] clip(input data_t v);
      if (in_range(v)) return v[WIDTH-1:0];
      return v[DW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction

   state_t            state, state_nx;
   logic [CNT_W-1:0]  iter_cnt;
   logic              mode_r, zero_r;
   data_t             x_r, y_r, x_nx, y_nx, x_ext, y_ext, x_ld, y_ld;
   angle_t            z_r, z_nx, z_ld, atan_cur;
   logic              accept, last_iter, d_pos;

   assign bus.in_ready  = (state == IDLE) && !reset;
   assign bus.out_valid = (state == DONE);
   assign accept        = bus.in_valid && bus.in_ready;
   assign last_iter     = (iter_cnt == CNT_W'(ITERATIONS - 1));
   assign x_ext         = {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
   assign y_ext         = {{2{bus.y_in[WIDTH-1]}}, bus.y_in};

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state: one pass through ITER per request, park in DONE until the result is taken.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept)        state_nx = ITER;
         ITER:    if (last_iter)     state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default:                    state_nx = IDLE;
      endcase
   end

   // Quadrant pre-reduction so the micro-rotations only ever cover +/- pi/2.
   always_comb begin
      x_ld = x_ext;
      y_ld = y_ext;
      z_ld = bus.z_in;
      if (bus.mode) begin
         z_ld = '0;
         if (bus.x_in[WIDTH-1]) begin
            x_ld = -x_ext;
            y_ld = -y_ext;
            z_ld = bus.y_in[WIDTH-1] ? -PI : PI;
         end
      end else if (bus.z_in > HALF_PI) begin
         x_ld = -x_ext;
         y_ld = -y_ext;
         z_ld = bus.z_in - PI;
      end else if (bus.z_in < -HALF_PI) begin
         x_ld = -x_ext;
         y_ld = -y_ext;
         z_ld = bus.z_in + PI;
      end
   end

   // One micro-rotation: drive z to zero (rotation) or y to zero (vectoring).
   always_comb begin
      d_pos    = mode_r ? y_r[DW-1] : ~z_r[ANGLE_WIDTH-1];
      atan_cur = to_angle(atan_base(int'(iter_cnt)));
      if (d_pos) begin
         x_nx = x_r - (y_r >>> iter_cnt);
         y_nx = y_r + (x_r >>> iter_cnt);
         z_nx = z_r - atan_cur;
      end else begin
         x_nx = x_r + (y_r >>> iter_cnt);
         y_nx = y_r - (x_r >>> iter_cnt);
         z_nx = z_r + atan_cur;
      end
   end

   // Working registers: load reduced operands on acceptance, then step once per cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         x_r      <= '0;
         y_r      <= '0;
         z_r      <= '0;
         mode_r   <= 1'b0;
         zero_r   <= 1'b0;
         iter_cnt <= '0;
      end else if (accept) begin
         x_r      <= x_ld;
         y_r      <= y_ld;
         z_r      <= z_ld;
         mode_r   <= bus.mode;
         zero_r   <= bus.mode && (bus.x_in == '0) && (bus.y_in == '0);
         iter_cnt <= '0;
      end else if (state == ITER) begin
         x_r      <= x_nx;
         y_r      <= y_nx;
         z_r      <= z_nx;
         iter_cnt <= iter_cnt + CNT_W'(1);
      end
   end

   // Result registers: captured from the final micro-rotation and held until the next result.
   always_ff @(posedge clock) begin
      if (reset) begin
         bus.x_out <= '0;
         bus.y_out <= '0;
         bus.z_out <= '0;
         bus.sat   <= 1'b0;
      end else if (state == ITER && last_iter) begin
         bus.x_out <= clip(x_nx);
         bus.y_out <= clip(y_nx);
         // A zero vector has no phase; report 0 rather than the accumulated table sum.
         bus.z_out <= zero_r ? '0 : z_nx;
         bus.sat   <= ~in_range(x_nx) | ~in_range(y_nx);
      end
   end
endmodule

// File: tb/tb_cordic_engine.sv
// tb_cordic_engine: directed table, randomized model comparison and handshake corner cases.
// Latency: checks ITERATIONS-cycle result latency and ITERATIONS+2 throughput.
// Backpressure: holds out_ready low with stray in_valid pulses and checks the result is frozen.
module tb_cordic_engine;
   localparam int W  = 16;
   localparam int N  = 15;
   localparam int AW = 32;

   logic clock = 1'b0;
   logic reset;

   cordic_engine_if #(.WIDTH(W), .ANGLE_WIDTH(AW)) bus ();

   cordic_engine #(.WIDTH(W), .ITERATIONS(N), .ANGLE_WIDTH(AW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int     tests = 0;
   int     fails = 0;
   longint atan_tab[N];
   longint pi_q;

   typedef struct {
      bit     m;
      int     x;
      int     y;
      longint z;
      int     ex;
      int     ey;
      longint ez;
      int     txy;
      longint tz;
      bit     esat;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input longint act, input longint exp, input longint tol);
      longint diff;
      diff = act - exp;
      if (diff < 0) diff = -diff;
      tests++;
      if (diff > tol) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
      end
   endtask

   // Reference: straight from the arithmetic rules, with $atan-derived constants.
   task automatic model(input bit m, input int xi, input int yi, input longint zi,
                        output longint xo, output longint yo, output longint zo, output bit so);
      longint x, y, z, xn, yn, d, hi, lo;
      x = xi; y = yi; z = zi;
      if (m) begin
         z = 0;
         if (xi < 0) begin
            x = -x; y = -y;
            z = (yi >= 0) ? pi_q : -pi_q;
         end
      end else if (2 * zi > pi_q) begin
         x = -x; y = -y; z = zi - pi_q;
      end else if (2 * zi < -pi_q) begin
         x = -x; y = -y; z = zi + pi_q;
      end
      for (int i = 0; i < N; i++) begin
         if (m) d = (y < 0) ? 1 : -1;
         else   d = (z >= 0) ? 1 : -1;
         xn = x - d * (y >>> i);
         yn = y + d * (x >>> i);
         z  = z - d * atan_tab[i];
         x  = xn;
         y  = yn;
      end
      hi = (64'sd1 <<< (W - 1)) - 1;
      lo = -(64'sd1 <<< (W - 1));
      so = 1'b0;
      if (x > hi) begin x = hi; so = 1'b1; end
      if (x < lo) begin x = lo; so = 1'b1; end
      if (y > hi) begin y = hi; so = 1'b1; end
      if (y < lo) begin y = lo; so = 1'b1; end
      zo = longint'(int'(z));
      if (m && xi == 0 && yi == 0) zo = 0;
      xo = x; yo = y;
   endtask

   task automatic wait_ready(input string tag);
      int k;
      k = 0;
      while (!bus.in_ready && k < 100) begin
         @(negedge clock);
         k++;
      end
      if (!bus.in_ready) begin
         tests++;
         fails++;
         $display("FAIL %s ready: in_ready=0 after 100 cycles, expected 1", tag);
      end
   endtask

   // Issue one request, scramble the inputs after acceptance, return the first valid result.
   task automatic run_op(input bit m, input int xi, input int yi, input longint zi, input string tag,
                         output longint xo, output longint yo, output longint zo, output bit so,
                         output int lat);
      wait_ready(tag);
      bus.mode     = m;
      bus.x_in     = W'(xi);
      bus.y_in     = W'(yi);
      bus.z_in     = AW'(zi);
      bus.in_valid = 1'b1;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (k == 1) begin
            bus.in_valid = 1'b0;
            bus.mode     = ~m;
            bus.x_in     = W'($urandom);
            bus.y_in     = W'($urandom);
            bus.z_in     = AW'($urandom);
         end
         if (bus.out_valid) begin
            lat = k - 1;
            break;
         end
      end
      xo = bus.x_out; yo = bus.y_out; zo = bus.z_out; so = bus.sat;
   endtask

   task automatic check_result(input string tag, input longint ax, input longint ay, input longint az,
                               input bit asat, input longint ex, input longint ey, input longint ez,
                               input bit esat, input longint txy, input longint tz);
      check({tag, " x_out"}, ax, ex, txy);
      check({tag, " y_out"}, ay, ey, txy);
      check({tag, " z_out"}, az, ez, tz);
      check({tag, " sat"}, longint'(asat), longint'(esat), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      longint rx, ry, rz, mx, my, mz, cx, cy, cz;
      bit     rs, ms, cs;
      int     lat, seen, prev;
      int     rises[$];
      bit     m;
      int     xi, yi;
      longint zi;

      pi_q = longint'($floor(3.14159265358979323846 * (2.0 ** (AW - 3)) + 0.5));
      for (int i = 0; i < N; i++)
         atan_tab[i] = longint'($floor($atan(2.0 ** (-i)) * (2.0 ** (AW - 3)) + 0.5));

      vecs[0] = '{1'b0, 9949, 0, 281104965, 14189, 8192, 0, 8, 32767, 1'b0};
      vecs[1] = '{1'b0, 9949, 0, 1610612736, -16220, 2312, 0, 8, 32768, 1'b0};
      vecs[2] = '{1'b0, 9949, 0, -1610612736, -16220, -2312, 0, 8, 32768, 1'b0};
      vecs[3] = '{1'b1, -16384, 16384, 0, 32767, 0, 1264972477, 8, 131072, 1'b1};
      vecs[4] = '{1'b1, 8000, 6000, 0, 16468, 0, 345477027, 8, 131072, 1'b0};
      vecs[5] = '{1'b1, -8000, -6000, 0, 16468, 0, -1341152686, 8, 131072, 1'b0};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.mode      = 1'b0;
      bus.x_in      = '0;
      bus.y_in      = '0;
      bus.z_in      = '0;

      // Reset state.
      repeat (2) @(negedge clock);
      check("reset in_ready", longint'(bus.in_ready), 0, 0);
      check("reset out_valid", longint'(bus.out_valid), 0, 0);
      check_result("reset", bus.x_out, bus.y_out, bus.z_out, bus.sat, 0, 0, 0, 1'b0, 0, 0);
      reset = 1'b0;
      @(negedge clock);
      check("post-reset in_ready", longint'(bus.in_ready), 1, 0);

      // Directed vectors with analytic expectations.
      bus.out_ready = 1'b1;
      for (int v = 0; v < 6; v++) begin
         run_op(vecs[v].m, vecs[v].x, vecs[v].y, vecs[v].z, $sformatf("vec%0d", v), rx, ry, rz, rs, lat);
         check($sformatf("vec%0d latency", v), lat, N, 0);
         check_result($sformatf("vec%0d", v), rx, ry, rz, rs,
                      vecs[v].ex, vecs[v].ey, vecs[v].ez, vecs[v].esat, vecs[v].txy, vecs[v].tz);
      end

      // Zero vector in vectoring mode.
      run_op(1'b1, 0, 0, 12345, "zero", rx, ry, rz, rs, lat);
      check_result("zero", rx, ry, rz, rs, 0, 0, 0, 1'b0, 0, 0);

      // Randomized requests against the model.
      for (int n = 0; n < 40; n++) begin
         m  = bit'($urandom_range(0, 1));
         xi = int'($urandom_range(0, 65535)) - 32768;
         yi = int'($urandom_range(0, 65535)) - 32768;
         zi = longint'(int'($urandom));
         model(m, xi, yi, zi, mx, my, mz, ms);
         run_op(m, xi, yi, zi, $sformatf("rand%0d", n), rx, ry, rz, rs, lat);
         check_result($sformatf("rand%0d", n), rx, ry, rz, rs, mx, my, mz, ms, 0, 0);
         repeat ($urandom_range(0, 3)) @(negedge clock);
      end

      // Backpressure: result frozen, stray requests ignored.
      bus.out_ready = 1'b0;
      run_op(1'b0, 9949, 0, 281104965, "bp", cx, cy, cz, cs, lat);
      check("bp latency", lat, N, 0);
      for (int c = 0; c < 20; c++) begin
         check($sformatf("bp%0d out_valid", c), longint'(bus.out_valid), 1, 0);
         check($sformatf("bp%0d in_ready", c), longint'(bus.in_ready), 0, 0);
         check($sformatf("bp%0d x_out", c), bus.x_out, cx, 0);
         bus.in_valid = (c % 2 == 0);
         bus.mode     = 1'b1;
         bus.x_in     = W'($urandom);
         bus.y_in     = W'($urandom);
         @(negedge clock);
      end
      bus.in_valid = 1'b0;
      check_result("bp held", bus.x_out, bus.y_out, bus.z_out, bus.sat, cx, cy, cz, cs, 0, 0);
      bus.out_ready = 1'b1;
      @(negedge clock);
      check("bp after handshake out_valid", longint'(bus.out_valid), 0, 0);
      check("bp after handshake in_ready", longint'(bus.in_ready), 1, 0);
      check_result("bp hold after handshake", bus.x_out, bus.y_out, bus.z_out, bus.sat, cx, cy, cz, cs, 0, 0);
      seen = 0;
      repeat (20) begin
         @(negedge clock);
         if (bus.out_valid) seen++;
      end
      check("bp ignored pulses out_valid count", seen, 0, 0);

      // Reset at iteration 5 aborts the operation.
      wait_ready("rst");
      bus.mode     = 1'b0;
      bus.x_in     = W'(9949);
      bus.y_in     = '0;
      bus.z_in     = AW'(281104965);
      bus.in_valid = 1'b1;
      @(negedge clock);
      bus.in_valid = 1'b0;
      repeat (5) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("rst out_valid", longint'(bus.out_valid), 0, 0);
      check_result("rst", bus.x_out, bus.y_out, bus.z_out, bus.sat, 0, 0, 0, 1'b0, 0, 0);
      seen = 0;
      repeat (20) begin
         @(negedge clock);
         if (bus.out_valid) seen++;
      end
      check("rst aborted out_valid count", seen, 0, 0);
      model(1'b1, 12000, -7000, 0, mx, my, mz, ms);
      run_op(1'b1, 12000, -7000, 0, "post-rst", rx, ry, rz, rs, lat);
      check("post-rst latency", lat, N, 0);
      check_result("post-rst", rx, ry, rz, rs, mx, my, mz, ms, 0, 0);

      // Back-to-back with in_valid and out_ready held high.
      wait_ready("b2b");
      bus.mode     = 1'b0;
      bus.x_in     = W'(5000);
      bus.y_in     = W'(-3000);
      bus.z_in     = AW'(-400000000);
      bus.in_valid = 1'b1;
      prev = 1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clock);
         if (bus.out_valid && prev == 0) rises.push_back(c);
         prev = bus.out_valid ? 1 : 0;
      end
      bus.in_valid = 1'b0;
      tests++;
      if (rises.size() < 5) begin
         fails++;
         $display("FAIL b2b result count: got %0d results, expected at least 5", rises.size());
      end else begin
         for (int i = 1; i < 5; i++)
            check($sformatf("b2b interval %0d", i), rises[i] - rises[i-1], N + 2, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/cordic_engine.md
# cordic_engine

Parametrised, handshaked successor to the single-mode iterative CORDIC. Computes either a vector rotation by a given angle (rotation mode) or the magnitude and phase of a vector (vectoring mode), one micro-rotation per cycle. Full-circle range reduction is built in, and outputs saturate with a flag. It sits between the NCO/phase-accumulator path and downstream mixers and magnitude detectors, behind valid/ready streams.

## Interface
- WIDTH, 16: coordinate width, signed Q2.(WIDTH-2); 1.0 = 2^(WIDTH-2).
- ITERATIONS, 15: micro-rotations; legal range 4..min(WIDTH, ANGLE_WIDTH-3).
- ANGLE_WIDTH, 32: angle width, signed radians in Q3.(ANGLE_WIDTH-3); 1 rad = 2^(ANGLE_WIDTH-3).
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input request.
- in_ready  out  1  high only in IDLE.
- mode  in  1  0 = rotation, 1 = vectoring; latched on acceptance.
- x_in, y_in  in  WIDTH  signed start vector.
- z_in  in  ANGLE_WIDTH  signed rotation angle (ignored in vectoring).
- out_valid  out  1  result available.
- out_ready  in  1  downstream accept.
- x_out, y_out  out  WIDTH  signed result coordinates, saturated.
- z_out  out  ANGLE_WIDTH  residual angle (rotation) or phase (vectoring).
- sat  out  1  x_out or y_out was clipped for this result.

## Operation
- FSM: IDLE -> ITER (ITERATIONS cycles) -> DONE -> IDLE. reset from any state -> IDLE.
- Acceptance: in_valid && in_ready at a rising edge. Range-reduced x, y, z are loaded into internal registers, the mode is latched, the counter i is set to 0, and the FSM moves to ITER.
- Internal x/y datapath is WIDTH+2 bits, sign-extended. z is ANGLE_WIDTH bits. PI = round(pi·2^(ANGLE_WIDTH-3)).
- Rotation range reduction:
  - z_in > PI/2: z = z_in − PI, x = −x_in, y = −y_in.
  - z_in < −PI/2: z = z_in + PI, x and y negated.
  - Otherwise pass through.
- Vectoring range reduction:
  - x_in < 0: negate x and y; z = +PI if y_in ≥ 0, else −PI.
  - Otherwise z = 0.
- Direction d:
  - Rotation: d = +1 if z ≥ 0, else −1.
  - Vectoring: d = +1 if y < 0, else −1.
- Iteration i:
  - x' = x − d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z − d·ATAN[i]
  - Shifts are arithmetic (floor). ATAN[i] = round(atan(2^-i)·2^(ANGLE_WIDTH-3)), held in a constant table.
- No gain compensation. Results carry K ≈ 1.64676; callers pre-scale by 1/K (0x26DD at WIDTH=16) when they need unit gain.
- Output stage on ITER exit:
  - Clip x and y to [−2^(WIDTH-1), 2^(WIDTH-1)−1].
  - sat = 1 if either coordinate clipped.
  - z passes through unclipped.
- Vectoring with x_in = y_in = 0: x_out = y_out = z_out = 0, sat = 0.

## Timing
- Reset values: in_ready = 0 during the reset cycle and 1 after it; out_valid = 0; x_out, y_out, z_out = 0; sat = 0.
- Latency: if acceptance is at edge E0, out_valid rises after edge E0+ITERATIONS.
- DONE:
  - out_valid is held high; x_out, y_out, z_out and sat are stable until out_ready = 1 at a rising edge.
  - The FSM then returns to IDLE. in_ready = 1 on the following cycle.
- Throughput: one result per ITERATIONS+2 cycles with out_ready tied high.
- Outputs hold the last result after the handshake, until the next DONE entry or reset.
- in_valid outside IDLE is ignored; there is no queueing.
- Reset mid-ITER or mid-DONE:
  - The operation is aborted and all outputs return to their reset values on the next edge.
  - No out_valid is produced for the aborted operation.
- mode, x_in, y_in and z_in are sampled only at acceptance; later changes have no effect.

## Test plan
All scenarios use WIDTH=16, ITERATIONS=15, ANGLE_WIDTH=32.
- Rotation: x=9949, y=0, z=281104965 (30°) -> x_out 14189±8, y_out 8192±8, \|z_out\| < 32768, sat=0.
- Rotation range reduction: x=9949, y=0, z=1610612736 (3 rad) -> x_out −16220±8, y_out 2312±8.
- Vectoring, second quadrant with saturation: x=−16384, y=16384 -> z_out 1264972477±2^17, y_out 0±8, x_out=32767, sat=1.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid and pulse in_valid during that time -> out_valid and outputs stay constant, in_ready=0, the pulses are ignored. Raising out_ready gives one handshake, then in_ready=1 on the next cycle.
- Reset mid-operation: assert reset at iteration 5 -> after the next edge, outputs are 0 and out_valid=0. A fresh request then completes normally with exactly 15-cycle latency.
- Zero vector in vectoring mode -> all outputs 0, sat=0. Back-to-back requests with out_ready=1 -> out_valid every 17 cycles.
